// File: rtl/uart_rx_configurable.sv
// UART receiver with elaboration-time frame format (5-9 data bits, optional parity, 1-2 stops).
// Words are presented on a valid/ready port; framing, parity and overrun errors pulse for one cycle.
module uart_rx_configurable #(
   parameter int unsigned DATA_BITS  = 8,
   parameter int unsigned OVERSAMPLE = 16,
   parameter int unsigned PARITY     = 0,
   parameter int unsigned STOP_BITS  = 1,
   parameter int unsigned HOLD_TICKS = 4
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 en_i,
   input  logic                 in_i,
   output logic                 busy_o,
   output logic                 out_valid_o,
   input  logic                 out_ready_i,
   output logic [DATA_BITS-1:0] out_o,
   output logic                 err_frame_o,
   output logic                 err_parity_o,
   output logic                 err_overrun_o
);

   localparam int unsigned CntW = $clog2(OVERSAMPLE);
   localparam int unsigned IdxW = $clog2(DATA_BITS);
   localparam int unsigned HcW  = $clog2(HOLD_TICKS + 1);

   localparam logic [CntW-1:0] HalfTick = CntW'(OVERSAMPLE / 2 - 1);
   localparam logic [CntW-1:0] LastTick = CntW'(OVERSAMPLE - 1);
   localparam logic [IdxW-1:0] LastData = IdxW'(DATA_BITS - 1);
   localparam logic [IdxW-1:0] LastStop = IdxW'(STOP_BITS - 1);
   localparam logic [HcW-1:0]  HoldMax  = HcW'(HOLD_TICKS);

   typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

   state_e               state_q;
   logic                 sync1_q, sync2_q, in_s;
   logic [HcW-1:0]       high_cnt_q, high_cnt_d;
   logic [CntW-1:0]      tick_q;
   logic [IdxW-1:0]      idx_q;
   logic [DATA_BITS-1:0] shreg_q, out_q;
   logic                 par_q, ferr_q, busy_q, out_valid_q;
   logic                 err_frame_q, err_parity_q, err_overrun_q;
   logic                 tick_done, frame_bad, par_bad, handshake;

   assign in_s      = sync2_q;
   assign tick_done = (tick_q == LastTick);
   assign handshake = out_valid_q && out_ready_i;
   // Only meaningful on the last stop sample: earlier stops are folded into ferr_q.
   assign frame_bad = ferr_q | ~in_s;

   always_comb begin
      par_bad = 1'b0;
      if (PARITY != 0) begin
         par_bad = ((^shreg_q) ^ par_q) != (PARITY == 2);
      end
   end

   always_comb begin
      high_cnt_d = '0;
      if (in_s) begin
         high_cnt_d = (high_cnt_q == HoldMax) ? high_cnt_q : high_cnt_q + 1'b1;
      end
   end

   // Synchroniser and idle-high tracker run regardless of en_i so a start is accepted at once.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync1_q    <= 1'b1;
         sync2_q    <= 1'b1;
         high_cnt_q <= '0;
      end else begin
         sync1_q    <= in_i;
         sync2_q    <= sync1_q;
         high_cnt_q <= high_cnt_d;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q       <= StIdle;
         tick_q        <= '0;
         idx_q         <= '0;
         shreg_q       <= '0;
         par_q         <= 1'b0;
         ferr_q        <= 1'b0;
         busy_q        <= 1'b0;
         out_valid_q   <= 1'b0;
         out_q         <= '0;
         err_frame_q   <= 1'b0;
         err_parity_q  <= 1'b0;
         err_overrun_q <= 1'b0;
      end else if (!en_i) begin
         state_q       <= StIdle;
         tick_q        <= '0;
         idx_q         <= '0;
         par_q         <= 1'b0;
         ferr_q        <= 1'b0;
         busy_q        <= 1'b0;
         out_valid_q   <= 1'b0;
         out_q         <= '0;
         err_frame_q   <= 1'b0;
         err_parity_q  <= 1'b0;
         err_overrun_q <= 1'b0;
      end else begin
         err_frame_q   <= 1'b0;
         err_parity_q  <= 1'b0;
         err_overrun_q <= 1'b0;
         if (handshake) begin
            out_valid_q <= 1'b0;
         end

         unique case (state_q)
            StIdle: begin
               if (!in_s && high_cnt_q == HoldMax) begin
                  state_q <= StStart;
                  tick_q  <= CntW'(1);
               end
            end

            StStart: begin
               if (tick_q == HalfTick) begin
                  if (in_s) begin
                     state_q <= StIdle;
                     tick_q  <= '0;
                  end else begin
                     state_q <= StData;
                     busy_q  <= 1'b1;
                     tick_q  <= '0;
                     idx_q   <= '0;
                     ferr_q  <= 1'b0;
                  end
               end else begin
                  tick_q <= tick_q + 1'b1;
               end
            end

            StData: begin
               if (tick_done) begin
                  tick_q  <= '0;
                  shreg_q <= {in_s, shreg_q[DATA_BITS-1:1]};
                  if (idx_q == LastData) begin
                     idx_q   <= '0;
                     state_q <= (PARITY != 0) ? StParity : StStop;
                  end else begin
                     idx_q <= idx_q + 1'b1;
                  end
               end else begin
                  tick_q <= tick_q + 1'b1;
               end
            end

            StParity: begin
               if (tick_done) begin
                  tick_q  <= '0;
                  par_q   <= in_s;
                  state_q <= StStop;
               end else begin
                  tick_q <= tick_q + 1'b1;
               end
            end

            StStop: begin
               if (tick_done) begin
                  tick_q <= '0;
                  if (idx_q == LastStop) begin
                     state_q <= StIdle;
                     busy_q  <= 1'b0;
                     idx_q   <= '0;
                     ferr_q  <= 1'b0;
                     if (frame_bad) begin
                        err_frame_q <= 1'b1;
                     end else if (par_bad) begin
                        err_parity_q <= 1'b1;
                     end else if (out_valid_q && !out_ready_i) begin
                        err_overrun_q <= 1'b1;
                     end else begin
                        out_q       <= shreg_q;
                        out_valid_q <= 1'b1;
                     end
                  end else begin
                     ferr_q <= ferr_q | ~in_s;
                     idx_q  <= idx_q + 1'b1;
                  end
               end else begin
                  tick_q <= tick_q + 1'b1;
               end
            end

            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign busy_o        = busy_q;
   assign out_valid_o   = out_valid_q;
   assign out_o         = out_q;
   assign err_frame_o   = err_frame_q;
   assign err_parity_o  = err_parity_q;
   assign err_overrun_o = err_overrun_q;

endmodule

// File: doc/uart_rx_configurable.md
# uart_rx_configurable

Parametrised UART receiver that deserialises one asynchronous serial line into DATA_BITS-wide words. Frame format is fixed at elaboration: 5–9 data bits, LSB first, optional even/odd parity, 1 or 2 stop bits. Received words are presented on a valid/ready output handshake, with per-frame framing, parity and overrun error reporting. It sits between the pin-side rx line and the host-side consumer (FIFO or register interface). It runs on the oversampling clock (baud × OVERSAMPLE).

## Interface
- DATA_BITS, 8: data bits per frame, legal 5..9.
- OVERSAMPLE, 16: clk ticks per bit, even, legal 8..32.
- PARITY, 0: 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1: legal 1 or 2.
- HOLD_TICKS, 4: minimum consecutive high samples required before a start edge is accepted, legal 1..OVERSAMPLE/2.
- clk  in  1  oversampling clock.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  receiver enable; low = synchronous flush to IDLE.
- in  in  1  rx line, asynchronous to clk.
- busy  out  1  frame reception in progress.
- out_valid  out  1  out holds an unconsumed word.
- out_ready  in  1  consumer accepts word when out_valid && out_ready.
- out  out  DATA_BITS  received word.
- err_frame  out  1  one-cycle pulse: stop bit sampled low.
- err_parity  out  1  one-cycle pulse: parity mismatch.
- err_overrun  out  1  one-cycle pulse: good frame lost because out_valid still set.

## Operation
- in is passed through a 2-flop synchroniser (flops reset to 1); only the synchronised sample (in_s) is used.
- high_cnt saturates at HOLD_TICKS while in_s = 1 and clears when in_s = 0.
- IDLE:
  - in_s = 0 with high_cnt == HOLD_TICKS → START, tick counter = 1.
  - in_s = 0 without enough prior high → stay in IDLE, no error.
- START:
  - At tick OVERSAMPLE/2 − 1, in_s = 1 → false start; return to IDLE silently.
  - At tick OVERSAMPLE/2 − 1, in_s = 0 → set busy, clear counter → DATA.
- DATA: sample in_s every OVERSAMPLE ticks into bit index 0..DATA_BITS−1. After the last data bit, go to PARITY if PARITY ≠ 0, else STOP.
- PARITY: sample one bit. Even parity requires XOR(data, parity bit) = 0; odd requires 1.
- STOP: sample STOP_BITS bits, one per OVERSAMPLE ticks. Any low stop sample marks a frame error. After the last stop sample, always return to IDLE and clear busy.
- Frame completion (the cycle after the last stop sample):
  - Frame error → err_frame pulse, word discarded.
  - Else parity error → err_parity pulse, word discarded.
  - Else if out_valid = 1 and no handshake in the same cycle → err_overrun pulse, new word discarded, old word kept.
  - Else out ← word, out_valid ← 1.
- out_valid clears on the cycle after out_valid && out_ready. out keeps its value until the next load.
- Completion coinciding with a handshake is not an overrun: the new word loads and out_valid stays 1.
- At most one error pulse per frame, priority frame > parity > overrun.
- en low: state ← IDLE, busy, out_valid, error pulses and counters cleared, out ← 0, on the next edge. high_cnt keeps tracking so a start can be accepted immediately after en rises.

## Timing
- Reset values: busy 0, out_valid 0, out 0, all err 0, state IDLE, high_cnt 0, synchroniser 1.
- Let t0 be the first cycle in_s = 0 that is accepted. in_s lags in by 2 clk.
- Start bit confirmed at t0 + OVERSAMPLE/2 − 1; busy is 1 from the next cycle.
- Bit k is sampled at t0 + OVERSAMPLE/2 − 1 + k·OVERSAMPLE:
  - data bits: k = 1..DATA_BITS
  - parity: next k
  - stops: following k values
- out_valid / error pulse: one cycle after the last stop sample. 8N1 with OVERSAMPLE = 16 → t0 + 152.
- busy falls in the same cycle out_valid rises.
- Back-to-back frames: a start edge is accepted from IDLE immediately after completion, as soon as HOLD_TICKS high samples have accumulated in the stop bit.
- Reset assertion mid-frame aborts immediately, asynchronously.

## Test plan
- 8N1, OVERSAMPLE = 16, send 0xA5, out_ready = 1 → out = 0xA5, out_valid high for exactly 1 cycle at t0 + 152, no err.
- PARITY = 1, send 0x5A (4 ones) with parity bit 1 → err_parity pulse, out_valid stays 0. Repeat with parity bit 0 → out = 0x5A.
- Send 0x3C with stop bit driven low → err_frame pulse, no out_valid, busy 0. The next correct frame 0x81 is received.
- out_ready = 0, send 0x11 then 0x22 → out = 0x11 held, err_overrun on the second completion. Assert out_ready → out_valid drops.
- Glitches:
  - 3-tick low glitch on in → no busy, no error.
  - Low after only 2 high ticks (HOLD_TICKS = 4) → ignored.
- DATA_BITS = 7, STOP_BITS = 2, send 0x55 then drop rst_n at bit 3 of a second frame → out = 0x55, then all outputs at reset values. Receiver accepts 0x2A after release.
